// File: rtl/sram_uart_dump_pkg.sv
// Shared state types for the top-level controllers.
// The SRAM dump FSM lives next to the top-level mode FSM.
package sram_uart_dump_pkg;

   localparam int SRAM_AW = 18;
   localparam int SRAM_DW = 16;

   typedef enum logic [1:0] {
      S_TOP_IDLE,
      S_TOP_UART_RX,
      S_TOP_DUMP
   } top_state_type;

   typedef enum logic [2:0] {
      S_TXD_IDLE,
      S_TXD_READ,
      S_TXD_WAIT,
      S_TXD_HIGH,
      S_TXD_LOW,
      S_TXD_DONE
   } tx_dump_state_type;

endpackage

// File: rtl/sram_uart_dump_tx.sv
// 8N1 byte serializer; empty is also high in the last clock of the
// stop bit so a new load chains frames with no idle gap.
module uart_tx_byte #(
   parameter int BAUD_DIV = 434
) (
   input  logic       CLOCK_50_I,
   input  logic       resetn,
   input  logic       load,
   input  logic [7:0] tx_byte,
   output logic       tx,
   output logic       empty
);

   localparam int BW = $clog2(BAUD_DIV + 1);

   logic [BW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [9:0]    frame;
   logic          active;
   logic          baud_tick;

   assign baud_tick = (baud_cnt == BW'(BAUD_DIV - 1));
   assign empty     = !active || (baud_tick && bit_cnt == 4'd9);
   assign tx        = frame[0];

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         frame    <= '1;
         active   <= 1'b0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
      end else if (load) begin
         frame    <= {1'b1, tx_byte, 1'b0};
         active   <= 1'b1;
         bit_cnt  <= '0;
         baud_cnt <= '0;
      end else if (active) begin
         if (baud_tick) begin
            baud_cnt <= '0;
            frame    <= {1'b1, frame[9:1]};
            if (bit_cnt == 4'd9)
               active <= 1'b0;
            else
               bit_cnt <= bit_cnt + 4'd1;
         end else begin
            baud_cnt <= baud_cnt + BW'(1);
         end
      end
   end

endmodule

// File: rtl/sram_uart_dump.sv
// Streams a block of SRAM words out of the UART, high byte first,
// prefetching the next word while the low byte is on the line.
import sram_uart_dump_pkg::*;

module sram_uart_dump #(
   parameter int BAUD_DIV = 434,
   parameter int RD_LAT   = 2
) (
   input  logic               CLOCK_50_I,
   input  logic               resetn,
   input  logic               Start,
   input  logic               Abort,
   input  logic [SRAM_AW-1:0] Start_address,
   input  logic [SRAM_AW-1:0] Word_count,
   output logic [SRAM_AW-1:0] SRAM_address,
   input  logic [SRAM_DW-1:0] SRAM_read_data,
   output logic               SRAM_we_n,
   output logic               UART_TX_O,
   output logic               Busy,
   output logic               Done
);

   localparam int LW = $clog2(RD_LAT + 1);

   tx_dump_state_type state, state_n;

   logic [SRAM_DW-1:0] word_reg;
   logic [SRAM_DW-1:0] hold_reg;
   logic [SRAM_AW-1:0] remain;
   logic [LW-1:0]      lat_cnt;
   logic               lat_done;
   logic               pf_pend;
   logic               abort_q;
   logic               tx_load;
   logic [7:0]         tx_data;
   logic               tx_empty;

   assign lat_done  = (lat_cnt == LW'(RD_LAT - 1));
   assign SRAM_we_n = 1'b1;
   assign Busy      = (state != S_TXD_IDLE);
   assign Done      = (state == S_TXD_DONE);

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_tx (
      .CLOCK_50_I (CLOCK_50_I),
      .resetn     (resetn),
      .load       (tx_load),
      .tx_byte    (tx_data),
      .tx         (UART_TX_O),
      .empty      (tx_empty)
   );

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn)
         state <= S_TXD_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      tx_load = 1'b0;
      tx_data = word_reg[7:0];
      unique case (state)
         S_TXD_IDLE:
            if (Start)
               state_n = (Word_count != '0) ? S_TXD_READ : S_TXD_DONE;
         S_TXD_READ:
            state_n = abort_q ? S_TXD_DONE : S_TXD_WAIT;
         S_TXD_WAIT:
            if (abort_q) begin
               state_n = S_TXD_DONE;
            end else if (lat_done) begin
               tx_load = 1'b1;
               tx_data = SRAM_read_data[15:8];
               state_n = S_TXD_HIGH;
            end
         S_TXD_HIGH:
            if (tx_empty) begin
               if (abort_q) begin
                  state_n = S_TXD_DONE;
               end else begin
                  tx_load = 1'b1;
                  state_n = S_TXD_LOW;
               end
            end
         S_TXD_LOW:
            if (tx_empty) begin
               if (abort_q || remain == SRAM_AW'(1)) begin
                  state_n = S_TXD_DONE;
               end else begin
                  tx_load = 1'b1;
                  tx_data = hold_reg[15:8];
                  state_n = S_TXD_HIGH;
               end
            end
         S_TXD_DONE:
            state_n = S_TXD_IDLE;
         default:
            state_n = S_TXD_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         SRAM_address <= '0;
         remain       <= '0;
         word_reg     <= '0;
         hold_reg     <= '0;
         lat_cnt      <= '0;
         pf_pend      <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         if (state == S_TXD_IDLE)
            abort_q <= 1'b0;
         else if (Abort)
            abort_q <= 1'b1;

         case (state)
            S_TXD_IDLE:
               if (Start && Word_count != '0) begin
                  SRAM_address <= Start_address;
                  remain       <= Word_count;
                  lat_cnt      <= '0;
               end
            S_TXD_READ:
               lat_cnt <= lat_cnt + LW'(1);
            S_TXD_WAIT: begin
               lat_cnt <= lat_cnt + LW'(1);
               if (lat_done)
                  word_reg <= SRAM_read_data;
            end
            S_TXD_HIGH:
               // Next address goes out as the low byte starts.
               if (tx_empty && !abort_q && remain != SRAM_AW'(1)) begin
                  SRAM_address <= SRAM_address + SRAM_AW'(1);
                  lat_cnt      <= '0;
                  pf_pend      <= 1'b1;
               end
            S_TXD_LOW: begin
               if (pf_pend) begin
                  if (lat_done) begin
                     hold_reg <= SRAM_read_data;
                     pf_pend  <= 1'b0;
                  end else begin
                     lat_cnt <= lat_cnt + LW'(1);
                  end
               end
               if (tx_empty) begin
                  remain   <= remain - SRAM_AW'(1);
                  word_reg <= hold_reg;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_uart_dump.sv
// Scoreboard bench: stimulus queues expected bytes, a UART
// receiver pops and compares each decoded frame.
module tb_sram_uart_dump;

   localparam int BD = 4;
   localparam int RL = 2;
   localparam int FR = 10 * BD;

   logic        CLOCK_50_I = 1'b0;
   logic        resetn = 1'b1;
   logic        Start = 1'b0;
   logic        Abort = 1'b0;
   logic [17:0] Start_address = '0;
   logic [17:0] Word_count = '0;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_read_data;
   logic        SRAM_we_n;
   logic        UART_TX_O;
   logic        Busy;
   logic        Done;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cnt = 0;
   int tx_low_cnt = 0;

   logic [7:0]  exp_q[$];
   int          rx_start_q[$];
   logic [15:0] mem [0:262143];
   logic [17:0] addr_d;

   sram_uart_dump #(
      .BAUD_DIV (BD),
      .RD_LAT   (RL)
   ) dut (
      .CLOCK_50_I     (CLOCK_50_I),
      .resetn         (resetn),
      .Start          (Start),
      .Abort          (Abort),
      .Start_address  (Start_address),
      .Word_count     (Word_count),
      .SRAM_address   (SRAM_address),
      .SRAM_read_data (SRAM_read_data),
      .SRAM_we_n      (SRAM_we_n),
      .UART_TX_O      (UART_TX_O),
      .Busy           (Busy),
      .Done           (Done)
   );

   always #5 CLOCK_50_I = ~CLOCK_50_I;

   // SRAM model: address seen at edge k gives data capturable at edge k+2
   always @(posedge CLOCK_50_I) begin
      cyc    <= cyc + 1;
      addr_d <= SRAM_address;
   end
   assign SRAM_read_data = mem[addr_d];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin : counters
      forever begin
         @(posedge CLOCK_50_I); #1;
         if (Done) done_cnt++;
         if (!UART_TX_O) tx_low_cnt++;
      end
   end

   initial begin : monitor
      int         st;
      logic [7:0] b;
      logic       stop;
      bit         ok;
      forever begin
         @(posedge CLOCK_50_I); #1;
         if (resetn && !UART_TX_O) begin
            st = cyc; ok = 1'b1; b = '0; stop = 1'b0;
            for (int i = 1; i <= FR - 2 && ok; i++) begin
               @(posedge CLOCK_50_I); #1;
               if (!resetn)
                  ok = 1'b0;
               else if (i % BD == BD / 2 && i / BD >= 1 && i / BD <= 8)
                  b[3'(i / BD - 1)] = UART_TX_O;
               else if (i % BD == BD / 2 && i / BD == 9)
                  stop = UART_TX_O;
            end
            if (ok) begin
               rx_start_q.push_back(st);
               chk("stop_bit", 32'(stop), 32'd1);
               if (exp_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_byte: got %02h expected none", b);
               end else begin
                  chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   task automatic do_start(input logic [17:0] a, input logic [17:0] n,
                           input logic ab, output int sc);
      Start_address = a;
      Word_count    = n;
      Start         = 1'b1;
      Abort         = ab;
      @(posedge CLOCK_50_I); #1;
      Start = 1'b0;
      Abort = 1'b0;
      sc    = cyc;
   endtask

   task automatic wait_done(input int lim, output int dc);
      dc = -1;
      for (int i = 0; i <= lim; i++) begin
         if (Done) begin
            dc = cyc;
            break;
         end
         @(posedge CLOCK_50_I); #1;
      end
      if (dc < 0) begin
         tests++; fails++;
         $display("FAIL done_timeout: got no Done expected Done within %0d", lim);
      end
   endtask

   task automatic wait_tx_low(input int lim, output int fs);
      fs = -1;
      for (int i = 0; i <= lim; i++) begin
         if (!UART_TX_O) begin
            fs = cyc;
            break;
         end
         @(posedge CLOCK_50_I); #1;
      end
      if (fs < 0) begin
         tests++; fails++;
         $display("FAIL start_bit_timeout: got line high expected start bit");
      end
   endtask

   task automatic post_check(input string tag, input int d0);
      @(posedge CLOCK_50_I); #1;
      chk({tag, "_busy_low"}, 32'(Busy), 32'd0);
      chk({tag, "_done_pulse"}, 32'(done_cnt - d0), 32'd1);
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge CLOCK_50_I);
      #1;
   endtask

   initial begin : stim
      int sc, dc, fs, d0, l0;
      for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
      mem[18'h00010] = 16'hA55A;
      mem[18'h00100] = 16'h0102;
      mem[18'h00101] = 16'h0304;
      mem[18'h00102] = 16'h0506;
      mem[18'h3FFFF] = 16'h1122;
      mem[18'h00000] = 16'h3344;
      mem[18'h00200] = 16'h8001;
      mem[18'h00201] = 16'h0203;
      mem[18'h00202] = 16'h0405;
      mem[18'h00203] = 16'h0607;

      #3 resetn = 1'b0;
      #1;
      chk("rst_tx", 32'(UART_TX_O), 32'd1);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_addr", 32'(SRAM_address), 32'd0);
      chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
      repeat (3) @(posedge CLOCK_50_I);
      #1 resetn = 1'b1;
      repeat (2) @(posedge CLOCK_50_I);
      #1;

      // single word
      rx_start_q.delete();
      exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
      d0 = done_cnt;
      do_start(18'h00010, 18'd1, 1'b0, sc);
      chk("t1_busy", 32'(Busy), 32'd1);
      wait_done(300, dc);
      chk("t1_frames", 32'(rx_start_q.size()), 32'd2);
      chk("t1_tx_time", 32'(dc - rx_start_q[0]), 32'd80);
      chk("t1_overhead", 32'((dc - sc) <= 80 + RL + 3), 32'd1);
      post_check("t1", d0);

      // three words, back-to-back frames, stray Start ignored
      rx_start_q.delete();
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      exp_q.push_back(8'h03); exp_q.push_back(8'h04);
      exp_q.push_back(8'h05); exp_q.push_back(8'h06);
      d0 = done_cnt;
      do_start(18'h00100, 18'd3, 1'b0, sc);
      repeat (50) @(posedge CLOCK_50_I);
      #1;
      do_start(18'h00010, 18'd1, 1'b0, fs);
      wait_done(600, dc);
      chk("t2_frames", 32'(rx_start_q.size()), 32'd6);
      for (int i = 1; i < 6; i++)
         chk("t2_no_gap", 32'(rx_start_q[i] - rx_start_q[i-1]), 32'(FR));
      post_check("t2", d0);

      // address wrap
      exp_q.push_back(8'h11); exp_q.push_back(8'h22);
      exp_q.push_back(8'h33); exp_q.push_back(8'h44);
      d0 = done_cnt;
      do_start(18'h3FFFF, 18'd2, 1'b0, sc);
      wait_done(400, dc);
      chk("t3_wrap_addr", 32'(SRAM_address), 32'd0);
      post_check("t3", d0);

      // abort during data bit 2 of the first high byte
      exp_q.push_back(8'h80);
      d0 = done_cnt;
      do_start(18'h00200, 18'd4, 1'b0, sc);
      wait_tx_low(20, fs);
      repeat (12) @(posedge CLOCK_50_I);
      #1 Abort = 1'b1;
      @(posedge CLOCK_50_I);
      #1 Abort = 1'b0;
      wait_done(300, dc);
      chk("t4_abort_time", 32'(dc - fs), 32'(FR));
      post_check("t4", d0);

      // Abort in idle, then Start+Abort together
      Abort = 1'b1;
      @(posedge CLOCK_50_I);
      #1 Abort = 1'b0;
      chk("t5_idle_abort", 32'(Busy), 32'd0);
      exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
      d0 = done_cnt;
      do_start(18'h00010, 18'd1, 1'b1, sc);
      wait_done(300, dc);
      post_check("t5", d0);

      // zero-length dump
      d0 = done_cnt;
      l0 = tx_low_cnt;
      do_start(18'h00020, 18'd0, 1'b0, sc);
      wait_done(3, dc);
      chk("t6_latency", 32'((dc - sc) <= 3), 32'd1);
      chk("t6_tx_idle", 32'(tx_low_cnt - l0), 32'd0);
      post_check("t6", d0);

      // reset mid-frame
      do_start(18'h00300, 18'd2, 1'b0, sc);
      wait_tx_low(20, fs);
      repeat (6) @(posedge CLOCK_50_I);
      #1;
      chk("t7_mid_frame_low", 32'(UART_TX_O), 32'd0);
      #2 resetn = 1'b0;
      #1;
      chk("t7_rst_tx", 32'(UART_TX_O), 32'd1);
      chk("t7_rst_busy", 32'(Busy), 32'd0);
      chk("t7_rst_done", 32'(Done), 32'd0);
      chk("t7_rst_addr", 32'(SRAM_address), 32'd0);
      repeat (2) @(posedge CLOCK_50_I);
      #1 resetn = 1'b1;
      l0 = tx_low_cnt;
      repeat (100) @(posedge CLOCK_50_I);
      #1;
      chk("t7_no_resume", 32'(tx_low_cnt - l0), 32'd0);
      chk("t7_busy_after", 32'(Busy), 32'd0);
      chk("t7_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
